rf_alu_pipe: RTL and testbench
==============================

Name: rf_alu_pipe

Overview:
Parametrised register-file-plus-ALU datapath for the multicycle RISC core, generalising the fixed 16-bit/8-register RF+ALU pair. It covers the register file (ID stage), the ID/EXE pipeline register and the ALU/immediate unit (EXE stage), plus an EXE output register. New over the previous generation:
- configurable width and depth;
- separate write-back address;
- write-through bypass;
- stall/flush;
- internal PSW (N,Z,C,V) register;
- 8-op ALU including logic ops.

Parameters:
DATA_W, 16, datapath width (even, >=8)
REG_N, 8, register count (power of 2); AW = log2(REG_N)
IMM_W, 8, immediate width (<= DATA_W)
INS_W, 11, instruction field width; must be >= max(3*AW, AW+IMM_W)

Ports:
clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Ins  in  INS_W  instruction; rd=[INS_W-1 -: AW], rm=[INS_W-1-AW -: AW], rn=[INS_W-1-2AW -: AW], imm=[IMM_W-1:0]
WBData  in  DATA_W  write-back data (ALU path)
MEMData  in  DATA_W  write-back data (memory path)
WBAddr  in  AW  write-back register index
WBRF  in  1  register-file write enable
WBresource  in  1  0: write WBData; 1: write MEMData
RBresource  in  1  read port B address: 0 = rn, 1 = rd
OprandB  in  1  ALU operand B: 0 = port B, 1 = zero-extended imm
LI  in  1  immediate mode: 1 = LHI, 0 = LLI
ALUop  in  3  ALU operation (see Behaviour)
Flag  in  1  PSW update enable for this instruction
Stall  in  1  hold the ID/EXE register
Flush  in  1  insert a bubble into the ID/EXE register
Rm  out  DATA_W  ID: RF[rm] (bypassed)
Rd  out  DATA_W  ID: port B read (bypassed)
Sum  out  DATA_W  EXE: combinational ALU result
LI_EXE  out  DATA_W  EXE: immediate-load result
OutR  out  DATA_W  registered Sum
N, Z, C, V  out  1  PSW register

Behaviour:
Reset (synchronous, active high):
- all RF entries, ID/EXE register, OutR and PSW clear to 0.
- During reset, WBRF is ignored.

Register file write:
- At posedge, if WBRF: RF[WBAddr] <= WBresource ? MEMData : WBData.

Reads (combinational):
- Rm = RF[rm]; Rd = RF[RBresource ? rd : rn].
- Bypass: if WBRF and WBAddr equals a read address, that port returns the write-data mux value in the same cycle.

ID/EXE register, at posedge:
- Reset: clear.
- else Stall: hold (Stall has priority over Flush).
- else Flush: clear, so Flag_e = 0 and no PSW change.
- else capture:
  - A_e = Rm;
  - B_e = OprandB ? zext(imm) : Rd;
  - D_e = Rd;
  - imm_e, LI_e, ALUop_e, Flag_e.

EXE stage (combinational from ID/EXE register and PSW):
- Cin = PSW.C. C is carry-out; for subtraction C = 1 means no borrow.
- ALUop encoding:
  - 000 ADD: A+B
  - 001 ADC: A+B+Cin
  - 010 SUB: A+~B+1
  - 011 SBC: A+~B+Cin
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 PASSB: B
- Arithmetic is computed at DATA_W+1 bits; the extra bit is C.
- V = signed overflow of the DATA_W result.
- LI_EXE:
  - LI_e = 1: {imm_e, D_e[DATA_W-IMM_W-1:0]}
  - LI_e = 0: zext(imm_e)
  - If IMM_W == DATA_W, both modes give imm_e.

EXE registers, at posedge (not Reset):
- OutR <= Sum, every cycle; Stall does not freeze it.
- If Flag_e:
  - N <= Sum[MSB]; Z <= (Sum == 0).
  - Arithmetic ops (000-011) also update C and V.
  - Logic ops and PASSB leave C and V unchanged.
- Flag_e is ignored while Stall is high, so a stalled instruction updates the PSW once.

Latency:
- ID inputs in cycle t → Sum/LI_EXE valid in cycle t+1 → OutR and PSW valid in cycle t+2.

Simultaneous events:
- Write plus read of the same register in the same cycle returns the new data.
- ADC/SBC use the PSW value before the current edge.
- Two back-to-back Flag instructions chain carry correctly.
- Reset mid-operation discards the in-flight EXE op.

Decomposition:
- Package rf_alu_pkg: ALUop localparams (ALU_ADD … ALU_PASSB), PSW bit indices, function clog2.
- Sub-module alu_core: combinational, parameter DATA_W; in A, B, Cin, op; out Sum, C, V.
- RF, pipeline register and PSW stay in rf_alu_pipe.

Test Plan:
1. Reset, then write RF[i] = i+1 for i = 0..7 via WBData → reading rm = i gives Rm = i+1; after Reset, all reads return 0.
2. Bypass: WBRF = 1, WBAddr = 3, WBData = 0xBEEF, rm = 3 in the same cycle → Rm = 0xBEEF in that cycle.
3. Arithmetic and flags:
   - R1 = 0xFFFF, R2 = 0x0001, ADD, Flag → next cycle Sum = 0x0000; following edge Z = 1, C = 1, N = 0, V = 0.
   - Then ADC R2+R2 → Sum = 0x0003.
   - SUB 0x8000 − 0x0001 → Sum = 0x7FFF, V = 1, C = 1.
4. Immediates, with R1 = 0x0404:
   - LHI, rd = 1, imm = 0x55 → LI_EXE = 0x5504.
   - LLI, imm = 0x44 → LI_EXE = 0x0044.
   - OprandB = 1, ADD, R1 + 0x44 → Sum = 0x0448.
5. Stall/Flush:
   - ADD with Flag, then Stall for 2 cycles → Sum held and PSW updated exactly once.
   - Flush with Flag = 1 on the input → Sum = A+B of zeros = 0, PSW unchanged.
   - Logic AND after a carry-set op → C stays 1.
6. Parameter sweep DATA_W = 32, REG_N = 16, INS_W = 14, IMM_W = 8: LDR path with WBresource = 1, MEMData = 0x12345678 into R15, then read → Rd = 0x12345678; LHI → LI_EXE = {0x55, R[23:0]}.

Source files
------------

// File: rtl/rf_alu_pkg.sv
// rf_alu_pkg: shared constants for the RF+ALU datapath.
//   ALU_*  : 3-bit ALU operation encodings (arithmetic ops have op[2] = 0)
//   PSW_*  : bit positions inside the 4-bit PSW register {N,Z,C,V}
//   clog2  : elaboration-time ceil(log2) used to size register indices
package rf_alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_ADC   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_SBC   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam int PSW_N = 3;
  localparam int PSW_Z = 2;
  localparam int PSW_C = 1;
  localparam int PSW_V = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 8-op ALU.
//   A, B  : operands
//   Cin   : carry in (PSW.C), used by ADC/SBC only
//   op    : ALU_* encoding from rf_alu_pkg
//   Sum   : result
//   C, V  : carry-out (no-borrow for subtraction) and signed overflow;
//           driven to 0 for logic ops and PASSB
module alu_core
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] Sum,
  output logic              C,
  output logic              V
);

  logic [DATA_W-1:0] b_eff;
  logic              cin_eff;
  logic [DATA_W:0]   ext;

  // Subtraction is A + ~B + carry; ADD/SUB force carry 0/1, ADC/SBC take Cin.
  assign b_eff   = op[1] ? ~B : B;
  assign cin_eff = op[0] ? Cin : op[1];
  assign ext     = {1'b0, A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_eff};

  always_comb begin
    Sum = ext[DATA_W-1:0];
    C   = ext[DATA_W];
    // Overflow: both addends share a sign that differs from the result's.
    V   = (A[DATA_W-1] == b_eff[DATA_W-1]) && (ext[DATA_W-1] != A[DATA_W-1]);
    case (op)
      ALU_AND:   begin Sum = A & B; C = 1'b0; V = 1'b0; end
      ALU_OR:    begin Sum = A | B; C = 1'b0; V = 1'b0; end
      ALU_XOR:   begin Sum = A ^ B; C = 1'b0; V = 1'b0; end
      ALU_PASSB: begin Sum = B;     C = 1'b0; V = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_alu_pipe.sv
// rf_alu_pipe: register file (ID), ID/EXE pipeline register, ALU and
// immediate unit (EXE), EXE output register and PSW.
//   clk, Reset      : clock, synchronous active-high reset
//   Ins             : instruction {rd, rm, rn, ...}, imm in the low IMM_W bits
//   WBData/MEMData  : write-back data, selected by WBresource
//   WBAddr, WBRF    : write-back index and enable
//   RBresource      : port B reads rd (1) or rn (0)
//   OprandB, LI     : ALU operand B select, LHI(1)/LLI(0) mode
//   ALUop, Flag     : operation and PSW update enable
//   Stall, Flush    : hold / bubble the ID/EXE register (Stall wins)
//   Rm, Rd          : ID-stage read ports with write-through bypass
//   Sum, LI_EXE     : EXE-stage combinational results
//   OutR, N/Z/C/V   : registered Sum and PSW
module rf_alu_pipe
  import rf_alu_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int REG_N  = 8,
  parameter  int IMM_W  = 8,
  parameter  int INS_W  = 11,
  localparam int AW     = clog2(REG_N)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [INS_W-1:0]  Ins,
  input  logic [DATA_W-1:0] WBData,
  input  logic [DATA_W-1:0] MEMData,
  input  logic [AW-1:0]     WBAddr,
  input  logic              WBRF,
  input  logic              WBresource,
  input  logic              RBresource,
  input  logic              OprandB,
  input  logic              LI,
  input  logic [2:0]        ALUop,
  input  logic              Flag,
  input  logic              Stall,
  input  logic              Flush,
  output logic [DATA_W-1:0] Rm,
  output logic [DATA_W-1:0] Rd,
  output logic [DATA_W-1:0] Sum,
  output logic [DATA_W-1:0] LI_EXE,
  output logic [DATA_W-1:0] OutR,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              V
);

  // ---------------- ID: decode + register file ----------------
  logic [AW-1:0]    rd_a, rm_a, rn_a, rb_a;
  logic [IMM_W-1:0] imm;

  assign rd_a = Ins[INS_W-1 -: AW];
  assign rm_a = Ins[INS_W-1-AW -: AW];
  assign rn_a = Ins[INS_W-1-2*AW -: AW];
  assign imm  = Ins[IMM_W-1:0];
  assign rb_a = RBresource ? rd_a : rn_a;

  logic                          we;
  logic [DATA_W-1:0]             wdata;
  logic [REG_N-1:0][DATA_W-1:0]  rf_q, rf_d;

  // Writes are suppressed during reset so the bypass cannot leak stale data.
  assign we    = WBRF & ~Reset;
  assign wdata = WBresource ? MEMData : WBData;

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[WBAddr] = wdata;
  end

  assign Rm = (we && (WBAddr == rm_a)) ? wdata : rf_q[rm_a];
  assign Rd = (we && (WBAddr == rb_a)) ? wdata : rf_q[rb_a];

  // ---------------- ID/EXE register ----------------
  logic [DATA_W-1:0] a_e_q, a_e_d, b_e_q, b_e_d, d_e_q, d_e_d;
  logic [IMM_W-1:0]  imm_e_q, imm_e_d;
  logic              li_e_q, li_e_d, flag_e_q, flag_e_d;
  logic [2:0]        op_e_q, op_e_d;

  always_comb begin
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    d_e_d    = d_e_q;
    imm_e_d  = imm_e_q;
    li_e_d   = li_e_q;
    op_e_d   = op_e_q;
    flag_e_d = flag_e_q;
    if (!Stall) begin
      if (Flush) begin
        a_e_d    = '0;
        b_e_d    = '0;
        d_e_d    = '0;
        imm_e_d  = '0;
        li_e_d   = 1'b0;
        op_e_d   = ALU_ADD;
        flag_e_d = 1'b0;
      end else begin
        a_e_d    = Rm;
        b_e_d    = OprandB ? DATA_W'(imm) : Rd;
        d_e_d    = Rd;
        imm_e_d  = imm;
        li_e_d   = LI;
        op_e_d   = ALUop;
        flag_e_d = Flag;
      end
    end
  end

  // ---------------- EXE: ALU + immediate unit ----------------
  logic [3:0]        psw_q, psw_d;
  logic [DATA_W-1:0] sum_w, outr_q, outr_d;
  logic              c_w, v_w;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .A   (a_e_q),
    .B   (b_e_q),
    .Cin (psw_q[PSW_C]),
    .op  (op_e_q),
    .Sum (sum_w),
    .C   (c_w),
    .V   (v_w)
  );

  assign Sum = sum_w;

  generate
    if (IMM_W == DATA_W) begin : g_li_full
      assign LI_EXE = imm_e_q;
    end else begin : g_li_part
      assign LI_EXE = li_e_q ? {imm_e_q, d_e_q[DATA_W-IMM_W-1:0]}
                             : DATA_W'(imm_e_q);
    end
  endgenerate

  // Only the low part of D_e (and LI_e) feeds LI_EXE; fold the rest away.
  logic unused_ok;
  assign unused_ok = ^{d_e_q, li_e_q};

  // ---------------- EXE registers ----------------
  // A stalled instruction sits in EXE for several cycles; only the cycle
  // that lets it leave may touch the PSW, so it updates exactly once.
  always_comb begin
    outr_d = sum_w;
    psw_d  = psw_q;
    if (flag_e_q && !Stall) begin
      psw_d[PSW_N] = sum_w[DATA_W-1];
      psw_d[PSW_Z] = (sum_w == '0);
      if (!op_e_q[2]) begin
        psw_d[PSW_C] = c_w;
        psw_d[PSW_V] = v_w;
      end
    end
  end

  assign OutR = outr_q;
  assign N    = psw_q[PSW_N];
  assign Z    = psw_q[PSW_Z];
  assign C    = psw_q[PSW_C];
  assign V    = psw_q[PSW_V];

  always_ff @(posedge clk) begin
    if (Reset) begin
      rf_q     <= '0;
      a_e_q    <= '0;
      b_e_q    <= '0;
      d_e_q    <= '0;
      imm_e_q  <= '0;
      li_e_q   <= 1'b0;
      op_e_q   <= ALU_ADD;
      flag_e_q <= 1'b0;
      outr_q   <= '0;
      psw_q    <= '0;
    end else begin
      rf_q     <= rf_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      d_e_q    <= d_e_d;
      imm_e_q  <= imm_e_d;
      li_e_q   <= li_e_d;
      op_e_q   <= op_e_d;
      flag_e_q <= flag_e_d;
      outr_q   <= outr_d;
      psw_q    <= psw_d;
    end
  end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// tb_rf_alu_pipe: directed + random bench for rf_alu_pipe. A cycle-level
// reference model (16-bit, 8 registers) predicts every output each cycle;
// a second 32-bit/16-register instance covers the wide configuration.
module tb_rf_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- default instance ----------------
  logic        rst;
  logic [10:0] ins;
  logic [15:0] wbd, memd;
  logic [2:0]  wba, aluop;
  logic        wbrf, wbres, rbres, oprb, li, flag, stall, flush;
  logic [15:0] rm_o, rd_o, sum_o, li_o, outr_o;
  logic        n_o, z_o, c_o, v_o;

  rf_alu_pipe dut (
    .clk(clk), .Reset(rst), .Ins(ins), .WBData(wbd), .MEMData(memd),
    .WBAddr(wba), .WBRF(wbrf), .WBresource(wbres), .RBresource(rbres),
    .OprandB(oprb), .LI(li), .ALUop(aluop), .Flag(flag), .Stall(stall),
    .Flush(flush), .Rm(rm_o), .Rd(rd_o), .Sum(sum_o), .LI_EXE(li_o),
    .OutR(outr_o), .N(n_o), .Z(z_o), .C(c_o), .V(v_o)
  );

  // ---------------- wide instance ----------------
  logic [13:0] ins2;
  logic [31:0] wbd2, mem2;
  logic [3:0]  wba2;
  logic        wbrf2, wbres2, rbres2, li2;
  logic [31:0] rm2, rd2, sum2, li2_o, outr2;
  logic        n2, z2, c2, v2;

  rf_alu_pipe #(.DATA_W(32), .REG_N(16), .IMM_W(8), .INS_W(14)) dut2 (
    .clk(clk), .Reset(rst), .Ins(ins2), .WBData(wbd2), .MEMData(mem2),
    .WBAddr(wba2), .WBRF(wbrf2), .WBresource(wbres2), .RBresource(rbres2),
    .OprandB(1'b0), .LI(li2), .ALUop(3'b000), .Flag(1'b0), .Stall(1'b0),
    .Flush(1'b0), .Rm(rm2), .Rd(rd2), .Sum(sum2), .LI_EXE(li2_o),
    .OutR(outr2), .N(n2), .Z(z2), .C(c2), .V(v2)
  );

  // ---------------- reference model state ----------------
  logic [15:0] m_rf [8];
  logic [15:0] e_a, e_b, e_d, m_outr;
  logic [7:0]  e_imm;
  logic [2:0]  e_op;
  logic        e_li, e_flag;
  logic        p_n, p_z, p_c, p_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic from first principles: unsigned sum/difference for C,
  // signed sum/difference range test for V.
  task automatic alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic cin, output logic [15:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, ci, r, sr;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    ci = cin ? 1 : 0;
    r = 0; sr = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin r = ua + ub;          sr = sa + sb;          c = (r > 65535); end
      3'd1: begin r = ua + ub + ci;     sr = sa + sb + ci;     c = (r > 65535); end
      3'd2: begin r = ua - ub;          sr = sa - sb;          c = (ua >= ub); end
      3'd3: begin r = ua - ub - 1 + ci; sr = sa - sb - 1 + ci; c = (ua >= ub + 1 - ci); end
      3'd4: r = int'(a & b);
      3'd5: r = int'(a | b);
      3'd6: r = int'(a ^ b);
      default: r = ub;
    endcase
    s = 16'(r);
    if (op < 3'd4) v = (sr > 32767) || (sr < -32768);
  endtask

  function automatic logic [15:0] rport(input logic [2:0] a);
    if (wbrf && !rst && wba == a) return wbres ? memd : wbd;
    return m_rf[a];
  endfunction

  task automatic check_model();
    logic [15:0] es; logic ec, ev;
    alu_ref(e_a, e_b, e_op, p_c, es, ec, ev);
    chk("Rm", 32'(rm_o), 32'(rport(ins[7:5])));
    chk("Rd", 32'(rd_o), 32'(rport(rbres ? ins[10:8] : ins[4:2])));
    chk("Sum", 32'(sum_o), 32'(es));
    chk("LI_EXE", 32'(li_o), e_li ? 32'({e_imm, e_d[7:0]}) : 32'(e_imm));
    chk("OutR", 32'(outr_o), 32'(m_outr));
    chk("PSW", 32'({n_o, z_o, c_o, v_o}), 32'({p_n, p_z, p_c, p_v}));
  endtask

  // Advance model by one edge from the current inputs, then let the DUT clock.
  task automatic edge_();
    logic [15:0] es, ra, rb; logic ec, ev;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      e_a = '0; e_b = '0; e_d = '0; e_imm = '0; e_li = 0; e_op = '0; e_flag = 0;
      m_outr = '0; p_n = 0; p_z = 0; p_c = 0; p_v = 0;
    end else begin
      alu_ref(e_a, e_b, e_op, p_c, es, ec, ev);
      ra = rport(ins[7:5]);
      rb = rport(rbres ? ins[10:8] : ins[4:2]);
      if (wbrf) m_rf[wba] = wbres ? memd : wbd;
      m_outr = es;
      if (e_flag && !stall) begin
        p_n = es[15]; p_z = (es == 16'h0);
        if (e_op < 3'd4) begin p_c = ec; p_v = ev; end
      end
      if (!stall) begin
        if (flush) begin
          e_a = '0; e_b = '0; e_d = '0; e_imm = '0; e_li = 0; e_op = '0; e_flag = 0;
        end else begin
          e_a = ra; e_b = oprb ? {8'h00, ins[7:0]} : rb; e_d = rb;
          e_imm = ins[7:0]; e_li = li; e_op = aluop; e_flag = flag;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic settle(); #2; check_model(); endtask
  task automatic cyc(); settle(); edge_(); endtask

  task automatic idle();
    ins = '0; wbd = '0; memd = '0; wba = '0; aluop = '0;
    wbrf = 0; wbres = 0; rbres = 0; oprb = 0; li = 0; flag = 0; stall = 0; flush = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    idle(); wbrf = 1; wba = a; wbd = d; cyc();
  endtask

  function automatic logic [10:0] mk(input logic [2:0] rd, input logic [2:0] rm, input logic [2:0] rn);
    return {rd, rm, rn, 2'b00};
  endfunction

  initial begin
    idle(); rst = 1;
    ins2 = '0; wbd2 = '0; mem2 = '0; wba2 = '0; wbrf2 = 0; wbres2 = 0; rbres2 = 0; li2 = 0;
    #2; edge_(); edge_();
    rst = 0;
    settle(); chk("reset_psw", 32'({n_o, z_o, c_o, v_o}), 32'h0);
    chk("reset_outr", 32'(outr_o), 32'h0); edge_();

    // 1. fill, read back, reset clears
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i + 1));
    for (int i = 0; i < 8; i++) begin
      idle(); ins = mk(0, 3'(i), 0); settle(); chk("rf_read", 32'(rm_o), 32'(i + 1)); edge_();
    end
    idle(); rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 8; i++) begin
      idle(); ins = mk(0, 3'(i), 0); settle(); chk("rf_clear", 32'(rm_o), 32'h0); edge_();
    end

    // 2. write-through bypass
    idle(); wbrf = 1; wba = 3; wbd = 16'hBEEF; ins = mk(0, 3, 0);
    settle(); chk("bypass", 32'(rm_o), 32'hBEEF); edge_();

    // 3. arithmetic and flags
    wr(1, 16'hFFFF); wr(2, 16'h0001);
    idle(); ins = mk(0, 1, 2); aluop = 3'd0; flag = 1; cyc();
    idle(); settle(); chk("add_wrap", 32'(sum_o), 32'h0); edge_();
    idle(); ins = mk(0, 2, 2); aluop = 3'd1; flag = 1;
    settle(); chk("add_psw", 32'({n_o, z_o, c_o, v_o}), 32'b0110); edge_();
    idle(); settle(); chk("adc", 32'(sum_o), 32'h3); edge_();
    wr(3, 16'h8000);
    idle(); ins = mk(0, 3, 2); aluop = 3'd2; flag = 1; cyc();
    idle(); settle(); chk("sub", 32'(sum_o), 32'h7FFF); edge_();
    idle(); settle(); chk("sub_cv", 32'({c_o, v_o}), 32'b11); edge_();

    // 4. immediates
    wr(1, 16'h0404); wr(2, 16'h0404);
    idle(); ins = {3'd1, 8'h55}; rbres = 1; li = 1; cyc();
    idle(); settle(); chk("lhi", 32'(li_o), 32'h5504); edge_();
    idle(); ins = {3'd0, 8'h44}; cyc();
    idle(); settle(); chk("lli", 32'(li_o), 32'h0044); edge_();
    idle(); ins = {3'd0, 8'h44}; oprb = 1; aluop = 3'd0; cyc();
    idle(); settle(); chk("add_imm", 32'(sum_o), 32'h0448); edge_();

    // 5. stall / flush / logic keeps C,V
    wr(5, 16'hFFFF); wr(6, 16'h0002);
    idle(); ins = mk(0, 5, 6); aluop = 3'd0; flag = 1; cyc();
    for (int k = 0; k < 2; k++) begin
      idle(); stall = 1; settle();
      chk("stall_sum", 32'(sum_o), 32'h1); chk("stall_v_held", 32'(v_o), 32'h1); edge_();
    end
    idle(); settle(); chk("stall_rel", 32'(sum_o), 32'h1); edge_();
    idle(); settle(); chk("stall_psw", 32'({n_o, z_o, c_o, v_o}), 32'b0010); edge_();
    idle(); ins = mk(0, 5, 6); aluop = 3'd0; flag = 1; flush = 1; cyc();
    idle(); settle(); chk("flush_sum", 32'(sum_o), 32'h0); edge_();
    idle(); settle(); chk("flush_psw", 32'({n_o, z_o, c_o, v_o}), 32'b0010); edge_();
    idle(); ins = mk(0, 3, 2); aluop = 3'd2; flag = 1; cyc();
    idle(); ins = mk(0, 3, 6); aluop = 3'd4; flag = 1; cyc();
    idle(); cyc();
    idle(); settle(); chk("and_keep_cv", 32'({n_o, z_o, c_o, v_o}), 32'b0111); edge_();

    // 6. wide configuration: memory write-back and LHI
    idle(); wbrf2 = 1; wba2 = 4'd15; wbres2 = 1; mem2 = 32'h12345678; wbd2 = 32'hDEADBEEF; cyc();
    wbrf2 = 0; ins2 = {4'd15, 10'd0}; rbres2 = 1;
    idle(); settle(); chk("w_ldr", rd2, 32'h12345678); edge_();
    ins2 = {4'd15, 2'b00, 8'h55}; li2 = 1; idle(); cyc();
    li2 = 0; rbres2 = 0; ins2 = '0;
    idle(); settle(); chk("w_lhi", li2_o, 32'h55345678); edge_();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      ins   = 11'($urandom);     wbd   = 16'($urandom); memd = 16'($urandom);
      wba   = 3'($urandom);      aluop = 3'($urandom);
      wbrf  = 1'($urandom);      wbres = 1'($urandom);  rbres = 1'($urandom);
      oprb  = 1'($urandom);      li    = 1'($urandom);  flag  = 1'($urandom);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 0; idle(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
